vga_timing_gen: RTL and testbench

// - Raster timing source; drives DrawX/DrawY/blank into the sprite/palette draw path, and hs/vs to the VGA pins.
// - Sprite blocks latch ROM data on negedge vga_clk and register colour on posedge, gated by blank.
// - This block produces the coordinates those blocks consume. Default mode is 640x480@60 Hz (25 MHz pixel clock).

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Raster timing defaults and the shared decode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vga_timing_pkg;

    // Counter width shared by both axes; the totals must fit in it.
    localparam int CNT_W    = 10;

    // 640x480@60 Hz with a 25 MHz pixel clock.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // True while cnt lies in the sync pulse window [start, start+width).
    function automatic logic sync_active(input logic [CNT_W-1:0] cnt,
                                         input int start, input int width);
        return (int'(cnt) >= start) && (int'(cnt) < start + width);
    endfunction

    // True while cnt lies in the visible region [0, limit).
    function automatic logic in_active(input logic [CNT_W-1:0] cnt, input int limit);
        return int'(cnt) < limit;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational active/sync decode of it.
// Latency: decode outputs are combinational from the registered count; wrap is combinational.
// Backpressure: none; advances whenever inc is high.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL  = H_TOTAL,
    parameter int ACTIVE = H_ACTIVE,
    parameter int FP     = H_FP,
    parameter int SYNC   = H_SYNC
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync_n
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // A total that does not fit the counter would silently alias positions.
    if ((TOTAL > (1 << CNT_W)) || (TOTAL < 2)) begin : g_bad_total
        $error("vga_axis_counter: TOTAL=%0d does not fit a %0d-bit counter", TOTAL, CNT_W);
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: hold unless inc; at the last position wrap to zero and flag it.
    always_comb begin
        wrap  = inc && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Position register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign active = in_active(cnt_q, ACTIVE);
    assign sync_n = !sync_active(cnt_q, ACTIVE + FP, SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster source: coordinates, syncs, blank and frame/line markers.
// Latency: every output is registered from the counters, so all outputs are mutually aligned.
// Backpressure: none; the raster never stalls.
module vga_timing_gen
    import vga_timing_pkg::CNT_W;
#(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int FCNT_W   = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic              sync,
    output logic [CNT_W-1:0]  DrawX,
    output logic [CNT_W-1:0]  DrawY,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters run one position ahead of DrawX/DrawY: their value is the
    // pixel presented after the next edge, so decoding them and registering
    // gives flags with zero skew against the coordinates.
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, h_active, h_sync_n;
    logic             v_wrap, v_active, v_sync_n;

    vga_axis_counter #(
        .TOTAL  (H_TOTAL),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC)
    ) u_h_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .inc     (1'b1),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .active  (h_active),
        .sync_n  (h_sync_n)
    );

    vga_axis_counter #(
        .TOTAL  (V_TOTAL),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC)
    ) u_v_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .inc     (h_wrap),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .active  (v_active),
        .sync_n  (v_sync_n)
    );

    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic [CNT_W-1:0]  draw_x_q, draw_x_d;
    logic [CNT_W-1:0]  draw_y_q, draw_y_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;

    // Decode the upcoming position; frame_count advances only on the end-of-frame wrap.
    always_comb begin
        draw_x_d      = h_cnt;
        draw_y_d      = v_cnt;
        hs_d          = h_sync_n;
        vs_d          = v_sync_n;
        blank_d       = h_active && v_active;
        line_start_d  = (h_cnt == '0);
        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        frame_count_d = frame_count_q;
        if (v_wrap) begin
            frame_count_d = frame_count_q + FCNT_W'(1);
        end
    end

    // Output registers; reset puts the pins in their idle (no-sync, blanked) state.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny 14x7 instance.
// Expected outputs come from an arithmetic raster model indexed by edges since reset release.
// Every sampled cycle is compared against the model on the falling clock edge.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Default-mode DUT.
    logic       rst_d = 1'b1;
    logic       d_hs, d_vs, d_blank, d_sync, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;

    vga_timing_gen u_dut_d (
        .vga_clk     (clk),
        .reset       (rst_d),
        .hs          (d_hs),
        .vs          (d_vs),
        .blank       (d_blank),
        .sync        (d_sync),
        .DrawX       (d_x),
        .DrawY       (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs),
        .frame_count (d_fc)
    );

    // Small-mode DUT: 14 x 7 raster, 98 cycles per frame.
    logic       rst_s = 1'b1;
    logic       s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .FCNT_W   (8)
    ) u_dut_s (
        .vga_clk     (clk),
        .reset       (rst_s),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank       (s_blank),
        .sync        (s_sync),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .frame_count (s_fc)
    );

    logic [33:0] obs_d, obs_s;
    assign obs_d = {d_hs, d_vs, d_blank, d_sync, d_ls, d_fs, d_x, d_y, d_fc};
    assign obs_s = {s_hs, s_vs, s_blank, s_sync, s_ls, s_fs, s_x, s_y, s_fc};

    // Rising edges seen since each DUT last left reset.
    longint kd = 0;
    longint ks = 0;
    always @(posedge clk) begin
        kd <= rst_d ? 64'd0 : kd + 1;
        ks <= rst_s ? 64'd0 : ks + 1;
    end

    // Raster model: after k edges the displayed pixel is number k-1 of the
    // endless raster; frames completed = k / (H_TOTAL*V_TOTAL).
    function automatic logic [33:0] model(input int ha, input int hf, input int hw, input int hb,
                                          input int va, input int vf, input int vw, input int vb,
                                          input longint k);
        int     ht, vt, x, y, fc;
        longint p;
        logic   bl, hsn, vsn;
        if (k == 0) return {1'b1, 1'b1, 4'b0000, 10'd0, 10'd0, 8'd0};
        ht  = ha + hf + hw + hb;
        vt  = va + vf + vw + vb;
        p   = k - 1;
        x   = int'(p % ht);
        y   = int'((p / ht) % vt);
        fc  = int'((k / (ht * vt)) % 256);
        bl  = (x < ha) && (y < va);
        hsn = !((x >= ha + hf) && (x < ha + hf + hw));
        vsn = !((y >= va + vf) && (y < va + vf + vw));
        return {hsn, vsn, bl, 1'b0, (x == 0), (x == 0 && y == 0), 10'(x), 10'(y), 8'(fc)};
    endfunction

    function automatic logic [33:0] model_d(input longint k);
        return model(640, 16, 96, 48, 480, 10, 2, 33, k);
    endfunction

    function automatic logic [33:0] model_s(input longint k);
        return model(8, 2, 2, 2, 4, 1, 1, 1, k);
    endfunction

    task automatic test_reset();
        logic [33:0] first_px;
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_d !== model_d(0)) begin
            fails++;
            $display("FAIL reset_default got %h exp %h", obs_d, model_d(0));
        end
        checks++;
        if (obs_s !== model_s(0)) begin
            fails++;
            $display("FAIL reset_small got %h exp %h", obs_s, model_s(0));
        end
        rst_d = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
        // First visible pixel: hs=vs=1, blank=1, line/frame start, origin, count 0.
        first_px = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 8'd0};
        checks++;
        if (obs_d !== first_px) begin
            fails++;
            $display("FAIL first_cycle got %h exp %h", obs_d, first_px);
        end
    endtask

    task automatic test_line();
        int n;
        int hs_fall, hs_rise;
        logic prev_hs;
        n = 3 * 800 + int'($urandom_range(0, 799));
        hs_fall = -1;
        hs_rise = -1;
        prev_hs = d_hs;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (obs_d !== model_d(kd)) begin
                fails++;
                $display("FAIL line k=%0d got %h exp %h", kd, obs_d, model_d(kd));
            end
            if (prev_hs && !d_hs && hs_fall < 0) hs_fall = int'(d_x);
            if (!prev_hs && d_hs && hs_rise < 0) hs_rise = int'(d_x);
            prev_hs = d_hs;
        end
        checks++;
        if (hs_fall != 656 || hs_rise != 752) begin
            fails++;
            $display("FAIL hs_edges got fall=%0d rise=%0d exp fall=656 rise=752", hs_fall, hs_rise);
        end
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < 3; r++) begin
            repeat (int'($urandom_range(50, 1500))) @(negedge clk);
            #2;
            rst_d = 1'b1;
            #1;
            checks++;
            if (obs_d !== model_d(0)) begin
                fails++;
                $display("FAIL async_reset got %h exp %h", obs_d, model_d(0));
            end
            repeat (2) @(negedge clk);
            rst_d = 1'b0;
            repeat (900) begin
                @(negedge clk);
                checks++;
                if (obs_d !== model_d(kd)) begin
                    fails++;
                    $display("FAIL restart k=%0d got %h exp %h", kd, obs_d, model_d(kd));
                end
            end
        end
    endtask

    task automatic test_small_frame();
        int n_blank, n_vs, n_hs;
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        n_blank = 0;
        n_vs    = 0;
        n_hs    = 0;
        repeat (3 * 98) begin
            @(negedge clk);
            checks++;
            if (obs_s !== model_s(ks)) begin
                fails++;
                $display("FAIL small k=%0d got %h exp %h", ks, obs_s, model_s(ks));
            end
            if (ks >= 1 && ks <= 98) begin
                n_blank += int'(s_blank);
                n_vs    += int'(!s_vs);
                n_hs    += int'(!s_hs);
            end
        end
        checks++;
        if (n_blank != 32 || n_vs != 14 || n_hs != 14) begin
            fails++;
            $display("FAIL small_counts got blank=%0d vs_low=%0d hs_low=%0d exp 32 14 14",
                     n_blank, n_vs, n_hs);
        end
    endtask

    task automatic test_wrap();
        int n_fs;
        rst_s = 1'b1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        n_fs = 0;
        repeat (256 * 98 + 10) begin
            @(negedge clk);
            checks++;
            if (obs_s !== model_s(ks)) begin
                fails++;
                $display("FAIL wrap k=%0d got %h exp %h", ks, obs_s, model_s(ks));
            end
            n_fs += int'(s_fs);
            if (ks == 255 * 98) begin
                checks++;
                if (s_fc !== 8'd255) begin
                    fails++;
                    $display("FAIL fc_255 got %0d exp 255", s_fc);
                end
            end
            if (ks == 256 * 98) begin
                checks++;
                if (s_fc !== 8'd0) begin
                    fails++;
                    $display("FAIL fc_wrap got %0d exp 0", s_fc);
                end
            end
        end
        checks++;
        if (n_fs != 257) begin
            fails++;
            $display("FAIL frame_start_count got %0d exp 257", n_fs);
        end
    endtask

    task automatic test_small_mid_reset();
        for (int r = 0; r < 4; r++) begin
            repeat (int'($urandom_range(1, 300))) @(negedge clk);
            #3;
            rst_s = 1'b1;
            #1;
            checks++;
            if (obs_s !== model_s(0)) begin
                fails++;
                $display("FAIL small_async_reset got %h exp %h", obs_s, model_s(0));
            end
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
            rst_s = 1'b0;
            repeat (200) begin
                @(negedge clk);
                checks++;
                if (obs_s !== model_s(ks)) begin
                    fails++;
                    $display("FAIL small_restart k=%0d got %h exp %h", ks, obs_s, model_s(ks));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_mid_reset();
        test_small_frame();
        test_wrap();
        test_small_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
